// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and command parser state encoding
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_ISSUE = 3'd4
    } parser_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // CLK cycles per bit, shared by the receiver and transmitter.
    localparam int BAUD_DIV = 868;

endpackage

// File: rtl/uart_timeout_timer.sv
// rtl/uart_timeout_timer.sv - inter-byte watchdog, saturating counter with expire flag
module uart_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;

    // Holds at LIMIT rather than wrapping; the parser leaves the active states on expiry.
    always_ff @(posedge CLK) begin
        if (!RST || i_clear || !i_enable) begin
            r_count <= '0;
        end else if (r_count != LIMIT) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - assembles SYNC/ADDR/DATA/CSUM frames into register write requests
module uart_cmd_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         DATA_BYTES     = 2,
    parameter int         TIMEOUT_CYCLES = 10000,
    parameter int         ADDR_W         = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [7:0]              RX_BYTE,
    input  logic                    RX_VALID,
    output logic                    WR_VALID,
    input  logic                    WR_READY,
    output logic [ADDR_W-1:0]       WR_ADDR,
    output logic [8*DATA_BYTES-1:0] WR_DATA,
    output logic                    CSUM_ERR,
    output logic                    TIMEOUT_ERR,
    output logic                    OVERRUN,
    output logic                    BUSY
);

    localparam int IDX_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BYTES - 1);

    parser_state_t           r_state, w_state_n;
    logic [ADDR_W-1:0]       r_addr, w_addr_n;
    logic [8*DATA_BYTES-1:0] r_data, w_data_n;
    logic [7:0]              r_acc, w_acc_n;
    logic [IDX_W-1:0]        r_idx, w_idx_n;
    logic                    r_wr_valid, w_wr_valid_n;
    logic                    r_csum_err, w_csum_err_n;
    logic                    r_to_err, w_to_err_n;
    logic                    r_ovr, w_ovr_n;
    logic                    w_active;
    logic                    w_expire;

    assign w_active = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);

    uart_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .i_clear  (RX_VALID),
        .i_enable (w_active),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state    <= ST_HUNT;
            r_addr     <= '0;
            r_data     <= '0;
            r_acc      <= '0;
            r_idx      <= '0;
            r_wr_valid <= 1'b0;
            r_csum_err <= 1'b0;
            r_to_err   <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_addr     <= w_addr_n;
            r_data     <= w_data_n;
            r_acc      <= w_acc_n;
            r_idx      <= w_idx_n;
            r_wr_valid <= w_wr_valid_n;
            r_csum_err <= w_csum_err_n;
            r_to_err   <= w_to_err_n;
            r_ovr      <= w_ovr_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_addr_n     = r_addr;
        w_data_n     = r_data;
        w_acc_n      = r_acc;
        w_idx_n      = r_idx;
        w_wr_valid_n = r_wr_valid;
        w_csum_err_n = 1'b0;
        w_to_err_n   = 1'b0;
        w_ovr_n      = 1'b0;

        case (r_state)
            ST_HUNT: begin
                if (RX_VALID && (RX_BYTE == SYNC_BYTE)) begin
                    w_acc_n   = '0;
                    w_state_n = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (RX_VALID) begin
                    w_addr_n  = ADDR_W'(RX_BYTE);
                    w_acc_n   = r_acc ^ RX_BYTE;
                    w_idx_n   = '0;
                    w_state_n = ST_DATA;
                end else if (w_expire) begin
                    w_to_err_n = 1'b1;
                    w_state_n  = ST_HUNT;
                end
            end
            ST_DATA: begin
                if (RX_VALID) begin
                    // Slot 0 lands in the most significant byte of WR_DATA.
                    for (int i = 0; i < DATA_BYTES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            w_data_n[8*(DATA_BYTES-1-i) +: 8] = RX_BYTE;
                        end
                    end
                    w_acc_n = r_acc ^ RX_BYTE;
                    if (r_idx == IDX_LAST) begin
                        w_state_n = ST_CSUM;
                    end else begin
                        w_idx_n = r_idx + IDX_W'(1);
                    end
                end else if (w_expire) begin
                    w_to_err_n = 1'b1;
                    w_state_n  = ST_HUNT;
                end
            end
            ST_CSUM: begin
                if (RX_VALID) begin
                    if (RX_BYTE == r_acc) begin
                        w_wr_valid_n = 1'b1;
                        w_state_n    = ST_ISSUE;
                    end else begin
                        w_csum_err_n = 1'b1;
                        w_state_n    = ST_HUNT;
                    end
                end else if (w_expire) begin
                    w_to_err_n = 1'b1;
                    w_state_n  = ST_HUNT;
                end
            end
            ST_ISSUE: begin
                // Bytes arriving here are lost, including on the transfer edge itself.
                if (RX_VALID) begin
                    w_ovr_n = 1'b1;
                end
                if (WR_READY) begin
                    w_wr_valid_n = 1'b0;
                    w_state_n    = ST_HUNT;
                end
            end
            default: begin
                w_wr_valid_n = 1'b0;
                w_state_n    = ST_HUNT;
            end
        endcase
    end

    assign WR_VALID    = r_wr_valid;
    assign WR_ADDR     = r_addr;
    assign WR_DATA     = r_data;
    assign CSUM_ERR    = r_csum_err;
    assign TIMEOUT_ERR = r_to_err;
    assign OVERRUN     = r_ovr;
    assign BUSY        = (r_state != ST_HUNT);

endmodule
